// File: rtl/rename_replay_seq_pkg.sv
// Shared rename types: sequence numbers, commit-shaped uops, replay FSM states.
// SqN compares are wrap-aware: the sign of the modular difference orders two SqNs.
package rename_replay_seq_pkg;

  localparam int SQN_W = 7;
  localparam int REPLAY_WIDTH = 4;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic       valid;
    logic       compressed;
    SqN         sqN;
    logic [4:0] rd;
    logic [6:0] tagDst;
  } CommitUOp;

  typedef enum logic [1:0] {RP_IDLE, RP_FLUSH, RP_REPLAY, RP_DRAIN} ReplayState_t;

  // $signed(a - b) > 0
  function automatic logic sqnPos(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  // $signed(a - b) < 0
  function automatic logic sqnNeg(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

endpackage

// File: rtl/rename_replay_seq_range.sv
// Per-lane ROB read requests for the window [rdPtr, endSqN) and how far rdPtr advances.
// Purely combinational; lanes are contiguous starting at lane 0.
module RangeLaneGen
  import rename_replay_seq_pkg::*;
#(
  parameter int W = REPLAY_WIDTH
) (
  input  logic                   en,
  input  SqN                     rdPtr,
  input  SqN                     endSqN,
  output logic [W-1:0]           laneValid,
  output SqN                     laneSqN [W],
  output logic [$clog2(W+1)-1:0] advance
);

  localparam int CNT_W = $clog2(W + 1);

  always_comb begin
    advance = '0;
    for (int i = 0; i < W; i++) begin
      laneSqN[i]   = rdPtr + SqN'(i);
      laneValid[i] = en && sqnPos(endSqN, laneSqN[i]);
      advance      = advance + CNT_W'(laneValid[i]);
    end
  end

endmodule

// File: rtl/rename_replay_seq.sv
// Mispredict replay sequencer: FLUSH 1 cycle, ceil(N/W) REPLAY cycles, DRAIN 1 cycle; no backpressure.
// Optional saturating perf counters are built when RENAME_REPLAY_PERF_EN is defined.
module rename_replay_seq
  import rename_replay_seq_pkg::*;
#(
  parameter int WIDTH_REPLAY = REPLAY_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    IN_branchTaken,
  input  SqN                      IN_branchSqN,
  input  SqN                      IN_robHeadSqN,
  output logic [WIDTH_REPLAY-1:0] OUT_robReadValid,
  output SqN                      OUT_robReadSqN [WIDTH_REPLAY],
  input  CommitUOp                IN_robReadUOp [WIDTH_REPLAY],
  output logic                    OUT_mispredFlush,
  output CommitUOp                OUT_replayUOp [WIDTH_REPLAY],
  output logic                    OUT_busy
`ifdef RENAME_REPLAY_PERF_EN
  ,
  output logic [31:0]             OUT_perfReplayEvents,
  output logic [31:0]             OUT_perfReplayCycles
`endif
);

  localparam int CNT_W = $clog2(WIDTH_REPLAY + 1);

  ReplayState_t            state;
  SqN                      rdPtr;
  SqN                      endSqN;
  logic [WIDTH_REPLAY-1:0] reqMask;

  logic [WIDTH_REPLAY-1:0] laneValid;
  SqN                      laneSqN [WIDTH_REPLAY];
  logic [CNT_W-1:0]        advance;

  SqN                      newEnd;
  logic                    olderBranch;
  SqN                      endEff;
  SqN                      rdNext;
  logic [WIDTH_REPLAY-1:0] keepMask;

  RangeLaneGen #(.W(WIDTH_REPLAY)) laneGen (
    .en        (state == RP_REPLAY),
    .rdPtr     (rdPtr),
    .endSqN    (endSqN),
    .laneValid (laneValid),
    .laneSqN   (laneSqN),
    .advance   (advance)
  );

  // An older mispredict shrinks the window; younger or equal ones are dropped.
  always_comb begin
    newEnd      = IN_branchSqN + SqN'(1);
    olderBranch = IN_branchTaken && sqnNeg(newEnd, endSqN);
    endEff      = olderBranch ? newEnd : endSqN;
    rdNext      = rdPtr + SqN'(advance);
    for (int i = 0; i < WIDTH_REPLAY; i++)
      keepMask[i] = laneValid[i] && sqnPos(endEff, laneSqN[i]);
  end

  always_comb begin
    OUT_robReadValid = laneValid;
    for (int i = 0; i < WIDTH_REPLAY; i++) begin
      OUT_robReadSqN[i]            = laneSqN[i];
      OUT_replayUOp[i]             = IN_robReadUOp[i];
      OUT_replayUOp[i].valid       = reqMask[i] && IN_robReadUOp[i].valid;
      OUT_replayUOp[i].compressed  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RP_IDLE;
      rdPtr            <= '0;
      endSqN           <= '0;
      reqMask          <= '0;
      OUT_busy         <= 1'b0;
      OUT_mispredFlush <= 1'b0;
    end else begin
      reqMask <= keepMask;
      case (state)
        RP_IDLE: begin
          if (IN_branchTaken) begin
            rdPtr            <= IN_robHeadSqN;
            endSqN           <= newEnd;
            state            <= RP_FLUSH;
            OUT_busy         <= 1'b1;
            OUT_mispredFlush <= 1'b1;
          end
        end
        RP_FLUSH: begin
          endSqN <= endEff;
          if (olderBranch && !sqnPos(endEff, rdPtr)) begin
            state <= RP_DRAIN;
          end else if (rdPtr != endSqN) begin
            state <= RP_REPLAY;
          end else begin
            state            <= RP_IDLE;
            OUT_busy         <= 1'b0;
            OUT_mispredFlush <= 1'b0;
          end
        end
        RP_REPLAY: begin
          rdPtr  <= rdNext;
          endSqN <= endEff;
          if (!sqnPos(endEff, rdNext))
            state <= RP_DRAIN;
        end
        default: begin
          endSqN           <= endEff;
          state            <= RP_IDLE;
          OUT_busy         <= 1'b0;
          OUT_mispredFlush <= 1'b0;
        end
      endcase
    end
  end

`ifdef RENAME_REPLAY_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_perfReplayEvents <= '0;
      OUT_perfReplayCycles <= '0;
    end else begin
      if (state == RP_IDLE && IN_branchTaken && OUT_perfReplayEvents != '1)
        OUT_perfReplayEvents <= OUT_perfReplayEvents + 32'd1;
      if (OUT_busy && OUT_perfReplayCycles != '1)
        OUT_perfReplayCycles <= OUT_perfReplayCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_replay_seq.sv
// Bench for rename_replay_seq: vector table plus directed recovery sequences, scoreboard on replay output.
module tb_rename_replay_seq;
  import rename_replay_seq_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         IN_branchTaken;
  SqN           IN_branchSqN;
  SqN           IN_robHeadSqN;
  logic [W-1:0] OUT_robReadValid;
  SqN           OUT_robReadSqN [W];
  CommitUOp     robData [W];
  logic         OUT_mispredFlush;
  CommitUOp     OUT_replayUOp [W];
  logic         OUT_busy;
`ifdef RENAME_REPLAY_PERF_EN
  logic [31:0]  perfEvents;
  logic [31:0]  perfCycles;
`endif

  rename_replay_seq #(.WIDTH_REPLAY(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IN_branchTaken   (IN_branchTaken),
    .IN_branchSqN     (IN_branchSqN),
    .IN_robHeadSqN    (IN_robHeadSqN),
    .OUT_robReadValid (OUT_robReadValid),
    .OUT_robReadSqN   (OUT_robReadSqN),
    .IN_robReadUOp    (robData),
    .OUT_mispredFlush (OUT_mispredFlush),
    .OUT_replayUOp    (OUT_replayUOp),
    .OUT_busy         (OUT_busy)
`ifdef RENAME_REPLAY_PERF_EN
    ,
    .OUT_perfReplayEvents (perfEvents),
    .OUT_perfReplayCycles (perfCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int busyCnt = 0;
  int flushCnt = 0;
  int readCnt = 0;
  SqN sb[$];
  logic killEn = 1'b0;
  SqN   killSqN = '0;

  task automatic check(input string nm, input logic ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic CommitUOp robEntry(input SqN s);
    CommitUOp u;
    u.valid      = 1'b1;
    u.compressed = 1'b0;
    u.sqN        = s;
    u.rd         = s[4:0] ^ 5'h15;
    u.tagDst     = s + 7'd3;
    return u;
  endfunction

  function automatic CommitUOp expReplay(input SqN s);
    CommitUOp u;
    u            = robEntry(s);
    u.compressed = 1'b1;
    return u;
  endfunction

  // ROB model: one-cycle read latency, optional invalid entry.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      robData[i]       <= robEntry(OUT_robReadSqN[i]);
      robData[i].valid <= !(killEn && OUT_robReadSqN[i] == killSqN);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (OUT_busy) busyCnt++;
      if (OUT_mispredFlush) flushCnt++;
      for (int i = 0; i < W; i++) if (OUT_robReadValid[i]) readCnt++;
      for (int i = 0; i < W; i++) begin
        if (OUT_replayUOp[i].valid) begin
          if (sb.size() == 0) begin
            check("unexpected_replay", 1'b0, OUT_replayUOp[i].sqN, -1);
          end else begin
            SqN e;
            e = sb.pop_front();
            check("replay_uop", OUT_replayUOp[i] === expReplay(e), OUT_replayUOp[i].sqN, e);
          end
        end
      end
    end
  end

  typedef struct {
    SqN  head;
    SqN  branch;
    logic kEn;
    SqN  kSqN;
    int  expBusy;
    int  expReads;
    int  expRep;
  } vec_t;

  vec_t vecs [7];

  task automatic pushRange(input SqN head, input SqN branch);
    SqN s;
    SqN e;
    s = head;
    e = branch + 7'd1;
    while (s != e) begin
      if (!(killEn && s == killSqN)) sb.push_back(s);
      s = s + 7'd1;
    end
  endtask

  task automatic clearCounts();
    busyCnt = 0;
    flushCnt = 0;
    readCnt = 0;
  endtask

  task automatic fire(input SqN head, input SqN branch);
    IN_robHeadSqN  = head;
    IN_branchSqN   = branch;
    IN_branchTaken = 1'b1;
    @(negedge clk);
    IN_branchTaken = 1'b0;
  endtask

  task automatic checkIdle(input string nm);
    check({nm, "_busy"}, OUT_busy == 1'b0, OUT_busy, 0);
    check({nm, "_flush"}, OUT_mispredFlush == 1'b0, OUT_mispredFlush, 0);
    check({nm, "_rdvalid"}, OUT_robReadValid == '0, OUT_robReadValid, 0);
    for (int i = 0; i < W; i++)
      check({nm, "_repvalid"}, OUT_replayUOp[i].valid == 1'b0, OUT_replayUOp[i].valid, 0);
  endtask

  initial begin
    vecs[0] = '{7'd10,  7'd16,  1'b0, 7'd0, 4, 7, 7};
    vecs[1] = '{7'd20,  7'd19,  1'b0, 7'd0, 1, 0, 0};
    vecs[2] = '{7'd125, 7'd1,   1'b0, 7'd0, 4, 5, 5};
    vecs[3] = '{7'd0,   7'd3,   1'b0, 7'd0, 3, 4, 4};
    vecs[4] = '{7'd40,  7'd40,  1'b0, 7'd0, 3, 1, 1};
    vecs[5] = '{7'd127, 7'd126, 1'b0, 7'd0, 1, 0, 0};
    vecs[6] = '{7'd5,   7'd12,  1'b1, 7'd9, 4, 8, 7};

    rst_n = 1'b0;
    IN_branchTaken = 1'b0;
    IN_branchSqN = '0;
    IN_robHeadSqN = '0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      killEn  = vecs[v].kEn;
      killSqN = vecs[v].kSqN;
      clearCounts();
      pushRange(vecs[v].head, vecs[v].branch);
      fire(vecs[v].head, vecs[v].branch);
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_busy_cycles", v), busyCnt == vecs[v].expBusy, busyCnt, vecs[v].expBusy);
      check($sformatf("v%0d_flush_cycles", v), flushCnt == vecs[v].expBusy, flushCnt, vecs[v].expBusy);
      check($sformatf("v%0d_reads", v), readCnt == vecs[v].expReads, readCnt, vecs[v].expReads);
      check($sformatf("v%0d_missing_replays", v), sb.size() == 0, sb.size(), 0);
      sb.delete();
    end
    killEn = 1'b0;

    // Older branch at 9 while rdPtr = 8 during replay of [0,30].
    clearCounts();
    pushRange(7'd0, 7'd9);
    fire(7'd0, 7'd30);
    repeat (3) @(negedge clk);
    check("older_rdvalid", OUT_robReadValid == 4'hF, OUT_robReadValid, 15);
    check("older_rdptr", OUT_robReadSqN[0] == 7'd8, OUT_robReadSqN[0], 8);
    fire(7'd0, 7'd9);
    check("older_drain_noreads", OUT_robReadValid == '0, OUT_robReadValid, 0);
    check("older_drain_busy", OUT_busy == 1'b1, OUT_busy, 1);
    repeat (8) @(negedge clk);
    check("older_busy_cycles", busyCnt == 5, busyCnt, 5);
    check("older_reads", readCnt == 12, readCnt, 12);
    check("older_missing_replays", sb.size() == 0, sb.size(), 0);
    sb.delete();

    // Younger branch during replay is ignored.
    clearCounts();
    pushRange(7'd10, 7'd16);
    fire(7'd10, 7'd16);
    @(negedge clk);
    fire(7'd0, 7'd40);
    repeat (8) @(negedge clk);
    check("younger_busy_cycles", busyCnt == 4, busyCnt, 4);
    check("younger_reads", readCnt == 7, readCnt, 7);
    check("younger_missing_replays", sb.size() == 0, sb.size(), 0);
    sb.delete();

    // Asynchronous reset in the middle of a replay.
    clearCounts();
    pushRange(7'd0, 7'd3);
    fire(7'd0, 7'd30);
    repeat (2) @(negedge clk);
    check("prereset_busy", OUT_busy == 1'b1, OUT_busy, 1);
    #2 rst_n = 1'b0;
    #1 checkIdle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    clearCounts();
    repeat (6) @(negedge clk);
    checkIdle("post_reset");
    check("post_reset_busy_cycles", busyCnt == 0, busyCnt, 0);
    check("post_reset_reads", readCnt == 0, readCnt, 0);
    check("post_reset_missing_replays", sb.size() == 0, sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
